wb_port_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline write-back stage and the multi-cycle multiply/divide unit (MDU). MDU results are queued in a small FIFO and written whenever the pipeline is not writing. The pipeline has priority. A starvation counter forces a one-cycle pipeline stall so that queued MDU results always retire. The block sits between the WB-stage result mux, the MDU and the register file write port.

---
 rtl/wb_port_arbiter_if.sv | 26 ++
 rtl/wb_port_arbiter.sv | 118 +++++++++++
 tb/tb_wb_port_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bus shared by the WB stage, the MDU and the arbiter.
// The arbiter connects through the slave modport; the pipeline/MDU/RF side uses master.
interface wb_port_arbiter_if;
  logic        pipe_wreg;
  logic [4:0]  pipe_rn;
  logic [31:0] pipe_wdi;
  logic        mdu_valid;
  logic [4:0]  mdu_rn;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic        stall;
  logic [2:0]  fifo_count;

  modport slave (
    input  pipe_wreg, pipe_rn, pipe_wdi, mdu_valid, mdu_rn, mdu_data,
    output mdu_ready, rf_we, rf_wn, rf_d, stall, fifo_count
  );

  modport master (
    output pipe_wreg, pipe_rn, pipe_wdi, mdu_valid, mdu_rn, mdu_data,
    input  mdu_ready, rf_we, rf_wn, rf_d, stall, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, MDU results queue in a FIFO,
// and a starvation counter forces a one-cycle stall. Optional macro: WB_ARB_BYPASS_EN.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                clrn,
  wb_port_arbiter_if.slave    bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [36:0]   mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [2:0]    count_r;
  logic [3:0]    wait_cnt_r;

  logic          empty_s;
  logic          force_s;
  logic          space_s;
  logic          grant_s;
  logic          pop_s;
  logic          push_s;
  logic          bypass_s;
  logic          stall_s;
  logic [4:0]    wn_s;
  logic [31:0]   d_s;
  logic [36:0]   head_s;

  assign empty_s = (count_r == 3'd0);
  assign space_s = (count_r < 3'(DEPTH));
  // The empty guard is redundant with wait_cnt clearing but keeps a pop off an empty FIFO.
  assign force_s = (wait_cnt_r == 4'(MAX_WAIT)) && !empty_s;
  assign head_s  = mem_r[rd_ptr_r];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    ptr_inc = (ptr == PW'(DEPTH - 1)) ? {PW{1'b0}} : ptr + PW'(1);
  endfunction

  // Grant selection and write-port mux.
  always_comb begin
    grant_s  = 1'b0;
    pop_s    = 1'b0;
    bypass_s = 1'b0;
    stall_s  = 1'b0;
    wn_s     = 5'd0;
    d_s      = 32'd0;
    if (force_s) begin
      grant_s = 1'b1;
      pop_s   = 1'b1;
      stall_s = bus.pipe_wreg;
      wn_s    = head_s[36:32];
      d_s     = head_s[31:0];
    end else if (bus.pipe_wreg) begin
      grant_s = 1'b1;
      wn_s    = bus.pipe_rn;
      d_s     = bus.pipe_wdi;
    end else if (!empty_s) begin
      grant_s = 1'b1;
      pop_s   = 1'b1;
      wn_s    = head_s[36:32];
      d_s     = head_s[31:0];
    end else begin
`ifdef WB_ARB_BYPASS_EN
      if (bus.mdu_valid) begin
        grant_s  = 1'b1;
        bypass_s = 1'b1;
        wn_s     = bus.mdu_rn;
        d_s      = bus.mdu_data;
      end else begin
        grant_s  = 1'b0;
      end
`else
      grant_s = 1'b0;
`endif
    end
  end

  assign push_s = bus.mdu_valid && space_s && !bypass_s;

  // Outputs are forced quiet while reset is asserted, even with requests pending.
  assign bus.rf_we      = clrn && grant_s && (wn_s != 5'd0);
  assign bus.rf_wn      = wn_s;
  assign bus.rf_d       = d_s;
  assign bus.stall      = clrn && stall_s;
  assign bus.mdu_ready  = clrn && space_s;
  assign bus.fifo_count = count_r;

  // FIFO storage, pointers, occupancy and head starvation counter.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 37'd0;
      end
      rd_ptr_r   <= {PW{1'b0}};
      wr_ptr_r   <= {PW{1'b0}};
      count_r    <= 3'd0;
      wait_cnt_r <= 4'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {bus.mdu_rn, bus.mdu_data};
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + {2'b00, push_s} - {2'b00, pop_s};
      if (empty_s || pop_s) begin
        wait_cnt_r <= 4'd0;
      end else if (wait_cnt_r != 4'(MAX_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed test-plan steps then random traffic,
// compared against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic [4:0]  rn;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic clrn;
  int   checks = 0;
  int   failures = 0;
  ent_t q[$];
  int   denied = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if bus();

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic wreg, input logic [4:0] prn, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mrn, input logic [31:0] md);
    bus.pipe_wreg = wreg;
    bus.pipe_rn   = prn;
    bus.pipe_wdi  = pd;
    bus.mdu_valid = mv;
    bus.mdu_rn    = mrn;
    bus.mdu_data  = md;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_we"},    32'(bus.rf_we), 32'd0);
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    check({tag, "_ready"}, 32'(bus.mdu_ready), 32'd0);
    check({tag, "_count"}, 32'(bus.fifo_count), 32'd0);
  endtask

  // One clock: inputs already driven at posedge+1; compare at negedge, then advance model.
  task automatic cycle(input string tag);
    logic        granted, from_fifo, direct, exp_stall, exp_ready, accept, was_empty;
    logic [4:0]  exp_wn;
    logic [31:0] exp_d;
    granted = 1'b0; from_fifo = 1'b0; direct = 1'b0; exp_stall = 1'b0;
    exp_wn = 5'd0; exp_d = 32'd0;
    #4;
    was_empty = (q.size() == 0);
    if (!was_empty && denied >= MAX_WAIT) begin
      granted = 1'b1; from_fifo = 1'b1; exp_stall = bus.pipe_wreg;
    end else if (bus.pipe_wreg) begin
      granted = 1'b1; exp_wn = bus.pipe_rn; exp_d = bus.pipe_wdi;
    end else if (!was_empty) begin
      granted = 1'b1; from_fifo = 1'b1;
    end else begin
`ifdef WB_ARB_BYPASS_EN
      if (bus.mdu_valid) begin
        granted = 1'b1; direct = 1'b1; exp_wn = bus.mdu_rn; exp_d = bus.mdu_data;
      end
`endif
    end
    if (from_fifo) begin
      exp_wn = q[0].rn;
      exp_d  = q[0].data;
    end
    exp_ready = (q.size() < DEPTH);
    accept    = bus.mdu_valid && exp_ready && !direct;
    check({tag, "_we"},    32'(bus.rf_we), 32'(granted && exp_wn != 5'd0));
    check({tag, "_stall"}, 32'(bus.stall), 32'(exp_stall));
    check({tag, "_ready"}, 32'(bus.mdu_ready), 32'(exp_ready));
    check({tag, "_count"}, 32'(bus.fifo_count), 32'(q.size()));
    if (granted) begin
      check({tag, "_wn"}, 32'(bus.rf_wn), 32'(exp_wn));
      check({tag, "_d"},  bus.rf_d, exp_d);
    end
    @(posedge clk);
    if (from_fifo) void'(q.pop_front());
    if (accept) q.push_back('{rn: bus.mdu_rn, data: bus.mdu_data});
    if (was_empty || from_fifo) denied = 0;
    else if (denied < MAX_WAIT) denied++;
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2;
    check_quiet("rst_low");
    bus.pipe_wreg = 1'b1;
    bus.pipe_rn   = 5'd3;
    #1;
    check_quiet("rst_low_req");
    bus.pipe_wreg = 1'b0;
    @(posedge clk);
    #3;
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Idle after release
    cycle("idle");
    check("idle_ready_const", 32'(bus.mdu_ready), 32'd1);

    // Pipeline only, then r0 suppression
    drive(1'b1, 5'd5, 32'h1, 1'b0, 5'd0, 32'd0);
    cycle("pipe5");
    drive(1'b1, 5'd0, 32'h2, 1'b0, 5'd0, 32'd0);
    cycle("pipe0");

    // Idle-port MDU write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hABCD);
    cycle("mdu_acc");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle("mdu_wr");
    cycle("mdu_empty");
    check("mdu_empty_const", 32'(bus.fifo_count), 32'd0);

    // Full FIFO under pipeline pressure, then starvation force
    drive(1'b1, 5'd9, 32'h900, 1'b1, 5'd11, 32'hB0);
    cycle("fill1");
    drive(1'b1, 5'd9, 32'h901, 1'b1, 5'd12, 32'hC0);
    cycle("fill2");
    drive(1'b1, 5'd9, 32'h902, 1'b1, 5'd13, 32'hD0);
    cycle("full");
    check("full_count_const", 32'(bus.fifo_count), 32'd2);
    drive(1'b1, 5'd9, 32'h903, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 8; i++) cycle("starve");

    // MDU entry aimed at r0 is popped without a write
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
    cycle("r0_acc");
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) cycle("r0_pop");

    // Async reset with two queued entries
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd20, 32'h20);
    cycle("q1");
    drive(1'b1, 5'd4, 32'h45, 1'b1, 5'd21, 32'h21);
    cycle("q2");
    check("q2_count_const", 32'(bus.fifo_count), 32'd2);
    #2;
    clrn = 1'b0;
    #1;
    check_quiet("arst");
    q.delete();
    denied = 0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(posedge clk);
    #2;
    clrn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) < 55),
            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            32'($urandom),
            1'($urandom_range(0, 99) < 45),
            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            32'($urandom));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
